// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Pipelined instruction fetch unit. Holds the fetch PC, issues in-order
//   requests to a ready/valid instruction memory, and buffers the returned
//   words together with their PCs in a DEPTH-entry FIFO that decode pops.
//   Branch/jump redirects flush the FIFO, retarget the PC and discard every
//   response still in flight for the old stream. A misaligned redirect target
//   raises a sticky fault and halts fetch until reset.
//
// Ports
//   clk              clock, all state updates on posedge
//   rst              synchronous active-low reset
//   fetch_en         1 = may issue new requests
//   imem_req_valid   request valid
//   imem_req_addr    request address (current fetch PC)
//   imem_req_ready   imem accepts the request this cycle
//   imem_resp_valid  response word valid (returned in request order)
//   imem_resp_data   response word
//   redirect_sel     00 none, 01 PC-relative, 10 register-indirect, 11 none
//   redirect_pc      PC of the redirecting instruction
//   redirect_imm     signed offset for PC-relative redirects
//   redirect_rs1     base register value for register-indirect redirects
//   instr_valid      FIFO head valid
//   instr_data       FIFO head instruction (zero when not valid)
//   instr_pc         FIFO head PC (zero when not valid)
//   instr_ready      decode pops the head when instr_valid & instr_ready
//   fetch_fault      sticky misaligned-target fault
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     ILEN         = 32,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic [1:0]      redirect_sel,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] redirect_imm,
  input  logic [XLEN-1:0] redirect_rs1,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            fault_q, fault_d;

  logic [ILEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];

  logic            run_s;
  logic            redir_s;
  logic [XLEN-1:0] target_s;
  logic            misaligned_s;
  logic [CW:0]     inflight_s;
  logic            credit_ok_s;
  logic            req_valid_s;
  logic            hs_s;
  logic            resp_acc_s;
  logic            resp_drop_s;
  logic            push_s;
  logic            instr_valid_s;
  logic            pop_s;

  // Decode of state, redirect target and the per-cycle handshake events
  always_comb begin
    run_s = 1'b0;
    case (state_q)
      ST_RUN:  run_s = 1'b1;
      ST_HALT: run_s = 1'b0;
      default: run_s = 1'b0;
    endcase

    redir_s = run_s & ((redirect_sel == 2'b01) | (redirect_sel == 2'b10));

    if (redirect_sel == 2'b01) begin
      target_s = redirect_pc + redirect_imm;
    end else begin
      // register-indirect jumps clear bit 0 of the computed address
      target_s = redirect_rs1 & {{(XLEN-1){1'b1}}, 1'b0};
    end
    misaligned_s = (target_s[1:0] != 2'b00);

    // credit: buffered words plus words still in flight may never exceed DEPTH,
    // so every response always finds a free FIFO slot
    inflight_s  = {1'b0, count_q} + {1'b0, outstanding_q};
    credit_ok_s = (inflight_s < (CW+1)'(DEPTH));

    // no request in a redirect cycle: the new target is issued next cycle
    req_valid_s = rst & run_s & fetch_en & credit_ok_s & ~redir_s;
    hs_s        = req_valid_s & imem_req_ready;

    // a response with nothing outstanding is stray and ignored entirely
    resp_acc_s  = imem_resp_valid & (outstanding_q != {CW{1'b0}});
    resp_drop_s = resp_acc_s & (drop_cnt_q != {CW{1'b0}});
    push_s      = resp_acc_s & ~resp_drop_s & run_s & ~redir_s;

    instr_valid_s = run_s & (count_q != {CW{1'b0}});
    // a flush makes a concurrent pop void
    pop_s         = instr_valid_s & instr_ready & ~redir_s;
  end

  // Next-state logic for PC, counters, FIFO pointers and FSM
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(hs_s) - CW'(resp_acc_s);
    drop_cnt_d    = drop_cnt_q - CW'(resp_drop_s);
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fault_d       = fault_q;

    if (redir_s) begin
      count_d  = {CW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      // everything still in flight belongs to the old stream; the response
      // arriving this cycle (if any) is discarded directly
      drop_cnt_d = outstanding_q + CW'(hs_s) - CW'(resp_acc_s);
      if (misaligned_s) begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end else begin
        fetch_pc_d = target_s;
        resp_pc_d  = target_s;
      end
    end else begin
      if (hs_s) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        wr_ptr_d  = wr_ptr_q + AW'(1);
        resp_pc_d = resp_pc_q + XLEN'(4);
      end else begin
        wr_ptr_d  = wr_ptr_q;
        resp_pc_d = resp_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
      count_q       <= {CW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      wr_ptr_q      <= {AW{1'b0}};
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fault_q       <= fault_d;
    end
  end

  // FIFO storage; entries are only read below count_q, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_q[wr_ptr_q] <= imem_resp_data;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = instr_valid_s;
  assign instr_data     = instr_valid_s ? data_mem_q[rd_ptr_q] : {ILEN{1'b0}};
  assign instr_pc       = instr_valid_s ? pc_mem_q[rd_ptr_q]   : {XLEN{1'b0}};
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_imm;
  logic [31:0] redirect_rs1;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;

  fetch_unit #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_sel(redirect_sel),
    .redirect_pc(redirect_pc), .redirect_imm(redirect_imm),
    .redirect_rs1(redirect_rs1), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // imem model: accepted requests answered lat cycles later, in order
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc;
  int    lat;
  bit    stray;

  int errors = 0;
  int checks = 0;

  // values sampled in the middle of the last cycle
  logic        o_req_valid, o_hs, o_instr_valid, o_fault, o_pop;
  logic [31:0] o_req_addr, o_instr_pc, o_instr_data;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        exp_req;
    logic        exp_fault;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vec[9];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // one clock cycle: present imem response, sample outputs, clock, update model
  task automatic cycle();
    if (stray) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_BAD0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].data;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    o_req_valid   = imem_req_valid;
    o_req_addr    = imem_req_addr;
    o_hs          = imem_req_valid & imem_req_ready;
    o_instr_valid = instr_valid;
    o_instr_pc    = instr_pc;
    o_instr_data  = instr_data;
    o_fault       = fetch_fault;
    o_pop         = instr_valid & instr_ready;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
    end else begin
      if (imem_resp_valid && !stray) mq.delete(0);
      if (o_hs) mq.push_back('{o_req_addr, data_of(o_req_addr), cyc + lat});
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect_sel = 2'b00; redirect_pc = 32'h0; redirect_imm = 32'h0;
    redirect_rs1 = 32'h0; stray = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc, exp_hs;
    logic [31:0] wrap_exp[3];
    int          nhs, npop;
    bit          found, seen;

    vec[0] = '{2'b01, 32'h0000_0008, 32'h0000_0020, 32'h0, 1'b0, 1'b0, 32'h0000_0028};
    vec[1] = '{2'b01, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0000_00FC};
    vec[2] = '{2'b10, 32'h0, 32'h0, 32'h0000_0101, 1'b0, 1'b0, 32'h0000_0100};
    vec[3] = '{2'b10, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'hFFFF_FFF8};
    vec[4] = '{2'b11, 32'h0000_0040, 32'h0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_000C};
    vec[5] = '{2'b00, 32'h0000_0040, 32'h0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_000C};
    vec[6] = '{2'b01, 32'h0, 32'h0000_0002, 32'h0, 1'b0, 1'b1, 32'h0};
    vec[7] = '{2'b10, 32'h0, 32'h0, 32'h0000_0102, 1'b0, 1'b1, 32'h0};
    vec[8] = '{2'b01, 32'h0000_0004, 32'h0000_001E, 32'h0, 1'b0, 1'b1, 32'h0};

    cyc = 0; lat = 1; rst = 1'b0; stray = 1'b0;

    // T1: reset state, issue sequence and 2-cycle fetch-to-decode latency
    do_reset();
    chk("reset req_valid", o_req_valid, 0);
    chk("reset req_addr", o_req_addr, 32'h0);
    chk("reset instr_valid", o_instr_valid, 0);
    chk("reset instr_data", o_instr_data, 32'h0);
    chk("reset instr_pc", o_instr_pc, 32'h0);
    chk("reset fetch_fault", o_fault, 0);
    for (int r = 0; r < 6; r++) begin
      cycle();
      chk("t1 req_valid", o_req_valid, 1);
      chk("t1 req_addr", o_req_addr, 32'(4 * r));
      if (r < 2) begin
        chk("t1 instr_valid early", o_instr_valid, 0);
      end else begin
        chk("t1 instr_valid", o_instr_valid, 1);
        chk("t1 instr_pc", o_instr_pc, 32'(4 * (r - 2)));
        chk("t1 instr_data", o_instr_data, data_of(32'(4 * (r - 2))));
      end
    end

    // T2: imem stall holds address, then decode backpressure limits issue to DEPTH
    do_reset();
    instr_ready = 1'b0; imem_req_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cycle();
      chk("t2 stall req_valid", o_req_valid, 1);
      chk("t2 stall addr held", o_req_addr, 32'h0);
    end
    imem_req_ready = 1'b1;
    nhs = 0;
    for (int r = 0; r < 12; r++) begin
      cycle();
      nhs += int'(o_hs);
    end
    chk("t2 requests under backpressure", nhs, 4);
    chk("t2 req_valid when full", o_req_valid, 0);
    instr_ready = 1'b1;
    exp_pc = 32'h0; exp_hs = 32'h10;
    for (int r = 0; r < 20; r++) begin
      cycle();
      if (o_pop) begin
        chk("t2 pop pc", o_instr_pc, exp_pc);
        chk("t2 pop data", o_instr_data, data_of(exp_pc));
        exp_pc += 32'h4;
      end
      if (o_hs) begin
        chk("t2 resumed addr", o_req_addr, exp_hs);
        exp_hs += 32'h4;
      end
    end
    chk("t2 enough pops", {31'b0, exp_pc >= 32'h20}, 1);

    // T3: redirect with stale responses in flight, imem latency 3
    lat = 3;
    do_reset();
    instr_ready = 1'b0;
    repeat (4) cycle();
    redirect_sel = 2'b01; redirect_pc = 32'h8; redirect_imm = 32'h20;
    cycle();
    chk("t3 head before redirect", o_instr_pc, 32'h0);
    chk("t3 no req in redirect cycle", o_req_valid, 0);
    redirect_sel = 2'b00; instr_ready = 1'b1;
    cycle();
    chk("t3 fifo flushed", o_instr_valid, 0);
    chk("t3 first new addr", o_req_addr, 32'h28);
    exp_pc = 32'h28; npop = 0;
    for (int r = 0; r < 12; r++) begin
      cycle();
      if (o_pop) begin
        chk("t3 pop pc", o_instr_pc, exp_pc);
        chk("t3 pop data", o_instr_data, data_of(exp_pc));
        exp_pc += 32'h4;
        npop++;
      end
    end
    chk("t3 pops after redirect", {31'b0, npop >= 3}, 1);

    // Redirect table: target computation, ignored selectors, misaligned faults
    lat = 1;
    for (int i = 0; i < 9; i++) begin
      do_reset();
      repeat (4) cycle();
      redirect_sel = vec[i].sel; redirect_pc = vec[i].pc;
      redirect_imm = vec[i].imm; redirect_rs1 = vec[i].rs1;
      cycle();
      chk("vec req_valid in redirect cycle", o_req_valid, vec[i].exp_req);
      redirect_sel = 2'b00;
      if (vec[i].exp_fault) begin
        cycle();
        chk("vec fetch_fault", o_fault, 1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
          // a redirect while halted must be ignored
          redirect_sel = (k == 2) ? 2'b10 : 2'b00;
          redirect_rs1 = 32'h40;
          cycle();
          seen |= o_req_valid | o_instr_valid;
        end
        redirect_sel = 2'b00;
        chk("vec halted outputs quiet", seen, 0);
        chk("vec fault sticky", o_fault, 1);
      end else begin
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
          cycle();
          if (o_instr_valid) begin
            found = 1'b1;
            chk("vec next instr_pc", o_instr_pc, vec[i].exp_pc);
            chk("vec next instr_data", o_instr_data, data_of(vec[i].exp_pc));
          end
        end
        chk("vec instr arrives", found, 1);
        chk("vec no fault", o_fault, 0);
      end
    end

    // T5: PC wraps modulo 2^32
    do_reset();
    redirect_sel = 2'b10; redirect_rs1 = 32'hFFFF_FFF8;
    cycle();
    chk("t5 no req in redirect cycle", o_req_valid, 0);
    redirect_sel = 2'b00;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
    for (int r = 0; r < 5; r++) begin
      cycle();
      if (r < 3) chk("t5 wrap addr", o_req_addr, wrap_exp[r]);
      if (r >= 2) chk("t5 wrap instr_pc", o_instr_pc, wrap_exp[r - 2]);
    end

    // T6: reset with 3 outstanding, stray response afterwards is ignored
    lat = 3;
    do_reset();
    instr_ready = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    cycle();
    chk("t6 reset req_valid", o_req_valid, 0);
    chk("t6 reset addr", o_req_addr, 32'h0);
    rst = 1'b1; cyc = 0; fetch_en = 1'b0; stray = 1'b1;
    cycle();
    chk("t6 idle req_valid", o_req_valid, 0);
    chk("t6 addr after reset", o_req_addr, 32'h0);
    stray = 1'b0;
    cycle();
    chk("t6 stray not pushed", o_instr_valid, 0);
    fetch_en = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (o_instr_valid) begin
        found = 1'b1;
        chk("t6 first pc", o_instr_pc, 32'h0);
        chk("t6 first data", o_instr_data, data_of(32'h0));
      end
    end
    chk("t6 instr arrives", found, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
